// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // First PC fetched out of reset.
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    // Canonical no-op (addi x0, x0, 0).
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    // Sequential fetch step, one 32-bit word.
    localparam logic [XLEN-1:0] PC_STEP = 32'h0000_0004;

    // One buffered fetch result as seen by the decoder.
    typedef struct packed {
        logic [ILEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

    // Forces a PC onto a word boundary; low two bits are never meaningful.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Circular-buffer index advance for buffers whose depth need not be a power of two.
    function automatic int wrap_inc(input int idx, input int depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
// The head entry is read straight out of the storage registers so the
// decoder-facing outputs come from flops. Push and pop in the same cycle
// are allowed at any fill level, including full.
module instruction_fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          do_pop_s;
    logic          do_push_s;

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Read/write pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= PW'(wrap_inc(int'(wr_ptr_r), DEPTH));
            end
            if (do_pop_s) begin
                rd_ptr_r <= PW'(wrap_inc(int'(rd_ptr_r), DEPTH));
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads as all-zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues in-order word reads to instruction
// memory, buffers returned words together with their PC and hands them to the
// decoder over valid/ready. Redirects flush the buffer and arm a drop counter
// so responses to requests issued before the redirect are thrown away.
//
// Requests are only issued when a buffer slot is guaranteed for the response
// (outstanding + buffered < FIFO_DEPTH), because memory responses cannot be
// back-pressured.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Architectural fetch state.
    logic [XLEN-1:0] pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_r;

    // In-order queue of PCs for requests whose responses will be kept.
    logic [XLEN-1:0] pcq_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   pcq_rd_r;
    logic [PW-1:0]   pcq_wr_r;

    // Next-state and control signals.
    logic [XLEN-1:0] pc_next_s;
    logic [CW-1:0]   outstanding_next_s;
    logic [CW-1:0]   drop_next_s;
    logic [CW:0]     in_use_s;
    logic            credit_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_drop_s;
    logic            rsp_keep_s;

    // Buffer interface.
    fetch_entry_t    fifo_push_entry_s;
    fetch_entry_t    fifo_head_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_pop_s;

    // Credit check, request issue and response classification.
    always_comb begin
        in_use_s    = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        credit_s    = (in_use_s < (CW+1)'(FIFO_DEPTH));
        req_valid_s = !redirect_valid && credit_s;
        req_fire_s  = req_valid_s && imem_req_ready;
        rsp_drop_s  = imem_rsp_valid && (redirect_valid || (drop_r != {CW{1'b0}}));
        rsp_keep_s  = imem_rsp_valid && !rsp_drop_s;
        fifo_pop_s  = !fifo_empty_s && inst_ready;

        fifo_push_entry_s.instruction = imem_rsp_data;
        fifo_push_entry_s.pc          = pcq_mem_r[pcq_rd_r];
        fifo_push_entry_s.fault       = imem_rsp_err;
    end

    // Next PC, outstanding-request count and stale-response drop count.
    always_comb begin
        pc_next_s          = pc_r;
        outstanding_next_s = outstanding_r;
        drop_next_s        = drop_r;

        if (redirect_valid) begin
            pc_next_s = align_pc(redirect_pc);
        end else if (req_fire_s) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end

        case ({req_fire_s, imem_rsp_valid})
            2'b10:   outstanding_next_s = outstanding_r + CW'(1);
            2'b01:   outstanding_next_s = outstanding_r - CW'(1);
            default: outstanding_next_s = outstanding_r;
        endcase

        // Everything still in flight at a redirect is stale; a response landing
        // in the redirect cycle itself is discarded here and not counted again.
        if (redirect_valid) begin
            if (imem_rsp_valid && (outstanding_r != {CW{1'b0}})) begin
                drop_next_s = outstanding_r - CW'(1);
            end else begin
                drop_next_s = outstanding_r;
            end
        end else if (rsp_drop_s) begin
            drop_next_s = drop_r - CW'(1);
        end else begin
            drop_next_s = drop_r;
        end
    end

    // PC and request/drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
        end else begin
            pc_r          <= pc_next_s;
            outstanding_r <= outstanding_next_s;
            drop_r        <= drop_next_s;
        end
    end

    // PC queue pointers; a redirect forgets every PC still waiting for data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcq_rd_r <= {PW{1'b0}};
            pcq_wr_r <= {PW{1'b0}};
        end else if (redirect_valid) begin
            pcq_rd_r <= {PW{1'b0}};
            pcq_wr_r <= {PW{1'b0}};
        end else begin
            if (req_fire_s) begin
                pcq_wr_r <= PW'(wrap_inc(int'(pcq_wr_r), FIFO_DEPTH));
            end
            if (rsp_keep_s) begin
                pcq_rd_r <= PW'(wrap_inc(int'(pcq_rd_r), FIFO_DEPTH));
            end
        end
    end

    // PC queue storage, written with the address of each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pcq_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (req_fire_s) begin
            pcq_mem_r[pcq_wr_r] <= pc_r;
        end
    end

    instruction_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (rsp_keep_s),
        .push_entry (fifo_push_entry_s),
        .pop        (fifo_pop_s),
        .head       (fifo_head_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s)
    );

    // Request valid is forced low while reset is held, independent of any clock.
    assign imem_req_valid = req_valid_s && rst_n;
    assign imem_req_addr  = pc_r;

    assign inst_valid  = !fifo_empty_s;
    assign instruction = fifo_head_s.instruction;
    assign inst_pc     = fifo_head_s.pc;
    assign inst_fault  = fifo_head_s.fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a randomized memory/decoder environment with a
// scoreboard of expected decoder entries, plus directed scenarios with
// hand-computed expectations.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];
    logic        pop_fault_log[$];
    int          pop_cyc_log[$];
    logic [31:0] fire_log[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          epoch = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_req_pc;
    logic [31:0] seq_pc;
    logic        cur_rsp_v;
    mreq_t       cur_rsp;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_inst_valid;
    logic [31:0] s_inst_pc;
    logic [31:0] s_instr;
    logic        s_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[6:2] == 5'd2);
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom_range(0, 4095);
        if ($urandom_range(0, 7) == 0) begin
            t = 32'hFFFF_FFF0 | {28'h0, t[3:0]};
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model.
    task automatic cycle(input logic rq_rdy, input logic i_rdy, input logic redir,
                         input logic [31:0] rpc);
        logic exp_rv;
        int   inflight;
        logic popped;
        imem_req_ready = rq_rdy;
        inst_ready     = i_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        cur_rsp_v      = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            cur_rsp   = mem_q.pop_front();
            cur_rsp_v = 1'b1;
        end
        imem_rsp_valid = cur_rsp_v;
        imem_rsp_data  = cur_rsp_v ? mem_word(cur_rsp.addr) : 32'h0;
        imem_rsp_err   = cur_rsp_v ? mem_err(cur_rsp.addr) : 1'b0;

        @(negedge clk);
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_instr      = instruction;
        s_fault      = inst_fault;

        inflight = mem_q.size() + (cur_rsp_v ? 1 : 0);
        exp_rv   = !redir && ((inflight + exp_q.size()) < 4);
        chk("req_valid", {31'h0, s_req_valid}, {31'h0, exp_rv});
        if (exp_rv) chk("req_addr", s_req_addr, exp_req_pc);
        chk("inst_valid", {31'h0, s_inst_valid}, {31'h0, exp_q.size() > 0});
        popped = 1'b0;
        if (exp_q.size() > 0) begin
            chk("inst_pc", s_inst_pc, exp_q[0].pc);
            chk("instruction", s_instr, exp_q[0].data);
            chk("inst_fault", {31'h0, s_fault}, {31'h0, exp_q[0].fault});
            if (i_rdy) begin
                chk("seq_pc", s_inst_pc, seq_pc);
                seq_pc = seq_pc + 32'h4;
                popped = 1'b1;
            end
        end
        if (s_inst_valid && i_rdy) begin
            pop_log.push_back(s_inst_pc);
            pop_fault_log.push_back(s_fault);
            pop_cyc_log.push_back(cyc);
        end

        if (s_req_valid && rq_rdy) begin
            mem_q.push_back('{addr: s_req_addr, epoch: epoch,
                              due: cyc + int'($urandom_range(lat_min, lat_max))});
            fire_log.push_back(s_req_addr);
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_req_pc = {rpc[31:2], 2'b00};
            seq_pc     = exp_req_pc;
        end else begin
            if (popped) void'(exp_q.pop_front());
            if (cur_rsp_v && cur_rsp.epoch == epoch) begin
                exp_q.push_back('{pc: cur_rsp.addr, data: mem_word(cur_rsp.addr),
                                  fault: mem_err(cur_rsp.addr)});
            end
            if (exp_rv && rq_rdy) exp_req_pc = exp_req_pc + 32'h4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
    endtask

    // Reset DUT and memory together; returns at posedge+1 with rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        mem_q.delete();
        exp_q.delete();
        exp_req_pc = 32'h0;
        seq_pc     = 32'h0;
        cyc        = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        pop_fault_log.delete();
        pop_cyc_log.delete();
        fire_log.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_instruction"}, instruction, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_inst_fault"}, {31'h0, inst_fault}, 32'h0);
    endtask

    initial begin
        int n_stale;
        rst_n = 1'b0;
        idle_inputs();

        // Reset held: everything quiet.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        // Streaming with 1-cycle memory; fault on 0x8.
        do_reset();
        clear_logs();
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel_req_valid", {31'h0, s_req_valid}, 32'h1);
        chk("rel_req_addr", s_req_addr, 32'h0);
        repeat (9) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_pop_cycle", pop_cyc_log[0], 32'd2);
        chk("stream_pc0", pop_log[0], 32'h0);
        chk("stream_pc1", pop_log[1], 32'h4);
        chk("stream_pc2", pop_log[2], 32'h8);
        chk("stream_pc3", pop_log[3], 32'hC);
        chk("stream_cyc3", pop_cyc_log[3], 32'd5);
        chk("fault_0x8", {31'h0, pop_fault_log[2]}, 32'h1);
        chk("fault_0x4", {31'h0, pop_fault_log[1]}, 32'h0);
        chk("fault_0xC", {31'h0, pop_fault_log[3]}, 32'h0);

        // Decoder stalled: exactly four requests, then resume at 0x10.
        do_reset();
        clear_logs();
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_fires", fire_log.size(), 32'd4);
        chk("stall_req_valid", {31'h0, s_req_valid}, 32'h0);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("drain_pc0", pop_log[0], 32'h0);
        chk("drain_pc1", pop_log[1], 32'h4);
        chk("drain_pc2", pop_log[2], 32'h8);
        chk("drain_pc3", pop_log[3], 32'hC);
        chk("resume_addr", fire_log[4], 32'h10);

        // Redirect with 0x8/0xC in flight (3-cycle memory).
        do_reset();
        clear_logs();
        lat_min = 3; lat_max = 3;
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h100);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        n_stale = 0;
        foreach (pop_log[i]) begin
            if (pop_log[i] == 32'h8 || pop_log[i] == 32'hC) n_stale++;
        end
        chk("stale_popped", n_stale, 32'd0);
        chk("redir_pc0", pop_log[2], 32'h100);
        chk("redir_pc1", pop_log[3], 32'h104);

        // Memory not ready: request held; redirect withdraws it.
        do_reset();
        clear_logs();
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            chk("hold_valid", {31'h0, s_req_valid}, 32'h1);
            chk("hold_addr", s_req_addr, 32'h4);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h203);
        chk("redir_req_valid", {31'h0, s_req_valid}, 32'h0);
        pop_log.delete();
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_redir_valid", {31'h0, s_req_valid}, 32'h1);
        chk("post_redir_addr", s_req_addr, 32'h200);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_redir_pop0", pop_log[0], 32'h200);
        chk("post_redir_pop1", pop_log[1], 32'h204);

        // Asynchronous reset pulse mid-stream, between clock edges.
        do_reset();
        clear_logs();
        lat_min = 1; lat_max = 2;
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("restart_valid", {31'h0, s_req_valid}, 32'h1);
        chk("restart_addr", s_req_addr, 32'h0);

        // Randomized traffic: variable latency, back-pressure, redirects.
        lat_min = 1; lat_max = 4;
        repeat (3000) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, rand_target());
        end
        repeat (1500) begin
            cycle(1'b1, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 40) == 0, rand_target());
        end
        lat_min = 1; lat_max = 1;
        repeat (500) begin
            cycle($urandom_range(0, 1) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0, rand_target());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
